// File: rtl/ub_arbiter_if.sv
// Port bundle for ub_arbiter: three requester handshakes plus the unified-buffer command bus.
// slave = arbiter side, master = requesters/buffer side.
interface ub_arbiter_if #(parameter int ADDRESS_SIZE = 10);
  logic                    host_req, host_we, host_section;
  logic [ADDRESS_SIZE-1:0] host_addr;
  logic                    host_gnt, host_done, host_err;
  logic                    comp_req, comp_we;
  logic [ADDRESS_SIZE-1:0] comp_addr;
  logic                    comp_gnt, comp_done, comp_err;
  logic                    store_req;
  logic [ADDRESS_SIZE-1:0] store_addr;
  logic                    store_gnt, store_done, store_err;
  logic                    ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section;
  logic [ADDRESS_SIZE-1:0] ub_address;
  logic                    ub_done;
  logic                    busy;

  modport slave (
    input  host_req, host_we, host_section, host_addr,
    input  comp_req, comp_we, comp_addr,
    input  store_req, store_addr, ub_done,
    output host_gnt, host_done, host_err,
    output comp_gnt, comp_done, comp_err,
    output store_gnt, store_done, store_err,
    output ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section, ub_address,
    output busy
  );

  modport master (
    output host_req, host_we, host_section, host_addr,
    output comp_req, comp_we, comp_addr,
    output store_req, store_addr, ub_done,
    input  host_gnt, host_done, host_err,
    input  comp_gnt, comp_done, comp_err,
    input  store_gnt, store_done, store_err,
    input  ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_store_en, ub_section, ub_address,
    input  busy
  );
endinterface

// File: rtl/ub_arbiter.sv
// Round-robin arbiter sharing the single-ported unified buffer between host, compute and store paths.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, with ub_done timeout and compute range check.
module ub_arbiter #(
  parameter int BUFFER_SIZE        = 1024,
  parameter int ADDRESS_SIZE       = $clog2(BUFFER_SIZE),
  parameter int BUFFER_WORD_SIZE   = 16,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ARRAY_SIZE         = 8,
  parameter int TIMEOUT_CYCLES     = 4
) (
  input logic       clk,
  input logic       rst,
  ub_arbiter_if.slave bus
);
  localparam int WPB = ARRAY_SIZE*ARRAY_SIZE*COMPUTE_DATA_WIDTH/BUFFER_WORD_SIZE;
  localparam int AW  = ADDRESS_SIZE;
  localparam int CW  = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {HOST = 2'd0, COMP = 2'd1, STORE = 2'd2} rid_e;

  state_e          state_q, state_d;
  rid_e            win_q, win_d, prio_q, prio_d;
  logic            we_q, we_d, sec_q, sec_d, err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  function automatic rid_e nxt(rid_e r);
    case (r)
      HOST:    return COMP;
      COMP:    return STORE;
      default: return HOST;
    endcase
  endfunction

  // prio_q is the first requester searched; it moves to one past the last winner
  logic [2:0] req;
  rid_e       c1, c2, pick;
  assign req = {bus.store_req, bus.comp_req, bus.host_req};

  always_comb begin
    c1   = nxt(prio_q);
    c2   = nxt(c1);
    pick = c2;
    if (req[prio_q])  pick = prio_q;
    else if (req[c1]) pick = c1;
  end

  // one extra bit so a block near the top of the buffer cannot wrap to look legal
  logic [AW:0] comp_end;
  logic        range_bad;
  assign comp_end  = {1'b0, bus.comp_addr} + (AW+1)'(WPB-1);
  assign range_bad = comp_end > (AW+1)'(BUFFER_SIZE-1);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    prio_d  = prio_q;
    we_d    = we_q;
    sec_d   = sec_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        win_d = pick;
        err_d = 1'b0;
        case (pick)
          HOST: begin
            we_d = bus.host_we; sec_d = bus.host_section; addr_d = bus.host_addr;
          end
          COMP: begin
            we_d = bus.comp_we; sec_d = 1'b0; addr_d = bus.comp_addr;
          end
          default: begin
            we_d = 1'b1; sec_d = 1'b0; addr_d = bus.store_addr;
          end
        endcase
        if (pick == COMP && range_bad) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ub_done) begin
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        prio_d  = nxt(win_q);
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= HOST;
      prio_q  <= HOST;
      we_q    <= 1'b0;
      sec_q   <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      sec_q   <= sec_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  logic issue, resp;
  assign issue = (state_q == ISSUE);
  assign resp  = (state_q == RESP);

  assign bus.host_gnt      = issue && win_q == HOST;
  assign bus.comp_gnt      = issue && win_q == COMP;
  assign bus.store_gnt     = issue && win_q == STORE;
  assign bus.host_done     = resp && win_q == HOST  && !err_q;
  assign bus.comp_done     = resp && win_q == COMP  && !err_q;
  assign bus.store_done    = resp && win_q == STORE && !err_q;
  assign bus.host_err      = resp && win_q == HOST  && err_q;
  assign bus.comp_err      = resp && win_q == COMP  && err_q;
  assign bus.store_err     = resp && win_q == STORE && err_q;
  assign bus.ub_we         = issue && we_q;
  assign bus.ub_re         = issue && !we_q;
  assign bus.ub_fifo_en    = issue && win_q == HOST;
  assign bus.ub_compute_en = issue && win_q == COMP;
  assign bus.ub_store_en   = issue && win_q == STORE;
  assign bus.ub_section    = issue && win_q == HOST && sec_q;
  assign bus.ub_address    = issue ? addr_q : '0;
  assign bus.busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ub_arbiter.sv
// Scoreboard bench for ub_arbiter: stimulus pushes hand-computed events (cycle-stamped),
// a monitor pops and compares on every cycle the DUT shows a grant/command or a response.
module tb_ub_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ub_arbiter_if #(.ADDRESS_SIZE(10)) bus();
  ub_arbiter #(.BUFFER_SIZE(1024)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  gnt, done, err;
    logic        we, re, fifo, comp, store, sec;
    logic [9:0]  addr;
  } ev_t;

  ev_t exp_q[$];
  int  vecs = 0, errs = 0, cyc = 0;
  bit  resp_en = 1'b1;
  logic resp_done = 1'b0, stray_done = 1'b0;
  assign bus.ub_done = resp_done | stray_done;

  initial forever begin @(posedge clk); cyc++; end

  // buffer model: answers each command with a one-cycle ub_done in the following cycle
  initial forever begin
    @(negedge clk);
    if ((bus.ub_we || bus.ub_re) && resp_en) begin
      @(posedge clk); #1 resp_done = 1'b1;
      @(posedge clk); #1 resp_done = 1'b0;
    end
  end

  ev_t  mon_o, mon_e;
  logic mon_act;
  initial forever begin
    @(negedge clk);
    mon_o       = '0;
    mon_o.cyc   = cyc;
    mon_o.gnt   = {bus.store_gnt, bus.comp_gnt, bus.host_gnt};
    mon_o.done  = {bus.store_done, bus.comp_done, bus.host_done};
    mon_o.err   = {bus.store_err, bus.comp_err, bus.host_err};
    mon_o.we    = bus.ub_we;
    mon_o.re    = bus.ub_re;
    mon_o.fifo  = bus.ub_fifo_en;
    mon_o.comp  = bus.ub_compute_en;
    mon_o.store = bus.ub_store_en;
    mon_o.sec   = bus.ub_section;
    mon_act = (|mon_o.gnt) || (|mon_o.done) || (|mon_o.err) || mon_o.we || mon_o.re ||
              mon_o.fifo || mon_o.comp || mon_o.store || mon_o.sec;
    mon_o.addr = (mon_o.we || mon_o.re || (|mon_o.gnt)) ? bus.ub_address : 10'h0;
    if (mon_act) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_event: got %h, required none", mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_o !== mon_e) begin
          errs++;
          $display("FAIL event: got %h, required %h", mon_o, mon_e);
        end
      end
    end
  end

  task automatic push_gnt(input int c, input int who, input bit we, input bit sec, input logic [9:0] a);
    ev_t e = '0;
    e.cyc = c; e.gnt[who] = 1'b1; e.we = we; e.re = !we;
    e.fifo = (who == 0); e.comp = (who == 1); e.store = (who == 2);
    e.sec = sec; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic push_resp(input int c, input int who, input bit err);
    ev_t e = '0;
    e.cyc = c;
    if (err) e.err[who] = 1'b1; else e.done[who] = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int who, input logic v);
    case (who)
      0:       bus.host_req  = v;
      1:       bus.comp_req  = v;
      default: bus.store_req = v;
    endcase
  endtask

  // wait for the requester's done/err, then drop its req in the following cycle
  task automatic wait_resp(input int who);
    int   n = 0;
    logic hit;
    forever begin
      @(negedge clk);
      hit = (who == 0) ? (bus.host_done  | bus.host_err)  :
            (who == 1) ? (bus.comp_done  | bus.comp_err)  :
                         (bus.store_done | bus.store_err);
      if (hit) break;
      n++;
      if (n > 40) begin
        vecs++; errs++;
        $display("FAIL resp_timeout_%0d: got no done/err, required one", who);
        break;
      end
    end
    step();
    set_req(who, 1'b0);
  endtask

  function automatic logic [31:0] outs();
    return {6'h0, bus.host_gnt, bus.comp_gnt, bus.store_gnt, bus.host_done, bus.comp_done,
            bus.store_done, bus.host_err, bus.comp_err, bus.store_err, bus.ub_we, bus.ub_re,
            bus.ub_compute_en, bus.ub_fifo_en, bus.ub_store_en, bus.ub_section,
            bus.ub_address, bus.busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  int c;
  initial begin
    rst = 1'b1;
    bus.host_req = 0; bus.host_we = 0; bus.host_section = 0; bus.host_addr = '0;
    bus.comp_req = 0; bus.comp_we = 0; bus.comp_addr = '0;
    bus.store_req = 0; bus.store_addr = '0;
    repeat (2) step();
    @(negedge clk);
    chk("reset_outs", outs(), 32'h0);
    step(); rst = 1'b0;
    step();

    // host byte write, high section
    c = cyc;
    bus.host_we = 1; bus.host_section = 1; bus.host_addr = 10'h005; bus.host_req = 1;
    push_gnt(c+1, 0, 1, 1, 10'h005);
    push_resp(c+3, 0, 0);
    wait_resp(0);
    @(negedge clk); chk("t2_busy_after", {31'h0, bus.busy}, 32'h0);
    step();

    // reset in the middle of WAIT aborts the store transaction silently
    resp_en = 0;
    c = cyc;
    bus.store_addr = 10'h200; bus.store_req = 1;
    push_gnt(c+1, 2, 1, 0, 10'h200);
    step(); step();
    rst = 1'b1; bus.store_req = 0;
    @(negedge clk); chk("reset_mid_wait", outs(), 32'h0);
    step(); step();
    rst = 1'b0; resp_en = 1;
    step();

    // three-way contention with held reqs; host goes first after reset
    c = cyc;
    bus.host_we = 0; bus.host_section = 0; bus.host_addr = 10'h010;
    bus.comp_we = 1; bus.comp_addr = 10'h020; bus.store_addr = 10'h030;
    bus.host_req = 1; bus.comp_req = 1; bus.store_req = 1;
    push_gnt(c+1, 0, 0, 0, 10'h010);  push_resp(c+3, 0, 0);
    push_gnt(c+5, 1, 1, 0, 10'h020);  push_resp(c+7, 1, 0);
    push_gnt(c+9, 2, 1, 0, 10'h030);  push_resp(c+11, 2, 0);
    push_gnt(c+13, 0, 0, 0, 10'h010); push_resp(c+15, 0, 0);
    fork
      begin wait_resp(0); step(); bus.host_req = 1; wait_resp(0); end
      begin wait_resp(1); end
      begin wait_resp(2); end
    join
    step();

    // compute range: last legal base, then first illegal base
    c = cyc;
    bus.comp_we = 0; bus.comp_addr = 10'h3F0; bus.comp_req = 1;
    push_gnt(c+1, 1, 0, 0, 10'h3F0); push_resp(c+3, 1, 0);
    wait_resp(1);
    step();
    c = cyc;
    bus.comp_addr = 10'h3F1; bus.comp_req = 1;
    push_resp(c+1, 1, 1);
    wait_resp(1);
    @(negedge clk); chk("t4_busy_after_err", {31'h0, bus.busy}, 32'h0);
    step();

    // timeout: buffer never answers
    resp_en = 0;
    c = cyc;
    bus.store_addr = 10'h123; bus.store_req = 1;
    push_gnt(c+1, 2, 1, 0, 10'h123); push_resp(c+6, 2, 1);
    wait_resp(2);
    @(negedge clk); chk("t5_busy_after_timeout", {31'h0, bus.busy}, 32'h0);
    resp_en = 1;
    step();

    // stray ub_done in IDLE, then a comp req that vanishes before the arbiter is free
    stray_done = 1; step(); stray_done = 0;
    @(negedge clk); chk("t6_busy_after_stray", {31'h0, bus.busy}, 32'h0);
    step();
    c = cyc;
    bus.host_we = 1; bus.host_section = 0; bus.host_addr = 10'h0AA; bus.host_req = 1;
    push_gnt(c+1, 0, 1, 0, 10'h0AA); push_resp(c+3, 0, 0);
    step(); bus.comp_we = 0; bus.comp_addr = 10'h100; bus.comp_req = 1;
    step(); bus.comp_req = 0;
    wait_resp(0);
    repeat (3) step();
    @(negedge clk); chk("t6_busy_idle", {31'h0, bus.busy}, 32'h0);

    step();
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
